// File: rtl/btn_debounce_sel.sv
// Push-button front end: two-flop synchroniser, per-button saturating debounce,
// press/release strobes and a latched "last pressed button" selector.
module btn_debounce_sel #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16,
    localparam int unsigned SEL_W          = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw_n,
    output logic [N_BTN-1:0] btn_db_n,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [SEL_W-1:0] sel_idx,
    output logic             sel_valid
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] db_q, db_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic [SEL_W-1:0] sel_idx_q, sel_idx_d;
    logic             sel_valid_q, sel_valid_d;

    // Any sample matching the accepted level restarts the count, so a bounce
    // can never accumulate towards a false transition.
    always_comb begin
        db_d      = db_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    db_d[i]      = sync2_q[i];
                    press_d[i]   = ~sync2_q[i];
                    release_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Descending scan so the lowest pressed index is the one that sticks.
    always_comb begin
        sel_idx_d   = sel_idx_q;
        sel_valid_d = sel_valid_q;
        for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
            if (press_q[i]) begin
                sel_idx_d   = SEL_W'(i);
                sel_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            db_q        <= '1;
            press_q     <= '0;
            release_q   <= '0;
            sel_idx_q   <= '0;
            sel_valid_q <= 1'b0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= btn_raw_n;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            press_q     <= press_d;
            release_q   <= release_d;
            sel_idx_q   <= sel_idx_d;
            sel_valid_q <= sel_valid_d;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_db_n      = db_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign sel_idx       = sel_idx_q;
    assign sel_valid     = sel_valid_q;

endmodule

// File: tb/tb_btn_debounce_sel.sv
// Bench for btn_debounce_sel: a DEBOUNCE_CYCLES=4 and a DEBOUNCE_CYCLES=1 instance share
// stimulus and are compared each cycle against a sample-window reference model.
module tb_btn_debounce_sel;

    localparam int D0 = 4;
    localparam int D1 = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw;

    logic [3:0] db0, pp0, rp0, db1, pp1, rp1;
    logic [1:0] sel0, sel1;
    logic       v0, v1;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    btn_debounce_sel #(.N_BTN(4), .DEBOUNCE_CYCLES(D0), .CNT_W(16)) u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .btn_raw_n    (raw),
        .btn_db_n     (db0),
        .press_pulse  (pp0),
        .release_pulse(rp0),
        .sel_idx      (sel0),
        .sel_valid    (v0)
    );

    btn_debounce_sel #(.N_BTN(4), .DEBOUNCE_CYCLES(D1), .CNT_W(16)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .btn_raw_n    (raw),
        .btn_db_n     (db1),
        .press_pulse  (pp1),
        .release_pulse(rp1),
        .sel_idx      (sel1),
        .sel_valid    (v1)
    );

    // Reference model: a level is accepted once the last D synchronised samples,
    // all taken since the previous acceptance or reset, differ from it.
    logic [3:0] m_s1  [2];
    logic [3:0] m_s2  [2];
    logic [3:0] m_db  [2];
    logic [3:0] m_pp  [2];
    logic [3:0] m_rp  [2];
    logic [1:0] m_sel [2];
    logic       m_v   [2];
    logic [7:0] m_win [2][4];
    int         m_fill[2][4];

    function automatic int dlen(input int k);
        return (k == 0) ? D0 : D1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [3:0] r);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_s1[k] = 4'hF; m_s2[k] = 4'hF; m_db[k] = 4'hF;
                m_pp[k] = 4'h0; m_rp[k] = 4'h0; m_sel[k] = 2'd0; m_v[k] = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    m_win[k][i] = 8'h0; m_fill[k][i] = 0;
                end
            end else begin
                if (m_pp[k] != 4'h0) begin
                    m_v[k] = 1'b1;
                    for (int j = 3; j >= 0; j--) if (m_pp[k][j]) m_sel[k] = 2'(j);
                end
                m_pp[k] = 4'h0;
                m_rp[k] = 4'h0;
                for (int i = 0; i < 4; i++) begin
                    logic all_diff;
                    m_win[k][i] = {m_win[k][i][6:0], m_s2[k][i]};
                    if (m_fill[k][i] < 8) m_fill[k][i]++;
                    all_diff = (m_fill[k][i] >= dlen(k));
                    for (int j = 0; j < dlen(k); j++)
                        if (m_win[k][i][j] == m_db[k][i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_db[k][i] = ~m_db[k][i];
                        if (m_db[k][i] == 1'b0) m_pp[k][i] = 1'b1;
                        else                    m_rp[k][i] = 1'b1;
                        m_fill[k][i] = 0;
                    end
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = r;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] r);
        @(negedge clk);
        reset = rst;
        raw   = r;
        @(posedge clk);
        model_edge(rst, r);
        #1;
        check_eq("db0", 32'(db0), 32'(m_db[0]));
        check_eq("press0", 32'(pp0), 32'(m_pp[0]));
        check_eq("release0", 32'(rp0), 32'(m_rp[0]));
        check_eq("sel0", 32'(sel0), 32'(m_sel[0]));
        check_eq("valid0", 32'(v0), 32'(m_v[0]));
        check_eq("db1", 32'(db1), 32'(m_db[1]));
        check_eq("press1", 32'(pp1), 32'(m_pp[1]));
        check_eq("release1", 32'(rp1), 32'(m_rp[1]));
        check_eq("sel1", 32'(sel1), 32'(m_sel[1]));
        check_eq("valid1", 32'(v1), 32'(m_v[1]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] r;
        int         presses;
        int         noisy;

        reset = 1'b1;
        raw   = 4'hF;
        step(1'b1, 4'hF);
        step(1'b1, 4'hF);

        // Idle after reset.
        repeat (20) step(1'b0, 4'hF);
        check_eq("t1_db", 32'(db0), 32'hF);
        check_eq("t1_sel", 32'(sel0), 32'h0);
        check_eq("t1_valid", 32'(v0), 32'h0);

        // Single press on button 1: accepted after edge E0+5.
        for (int n = 1; n <= 7; n++) begin
            step(1'b0, 4'hD);
            if (n == 5) check_eq("t2_db_early", 32'(db0), 32'hF);
            if (n == 6) begin
                check_eq("t2_db", 32'(db0), 32'hD);
                check_eq("t2_press", 32'(pp0), 32'h2);
                check_eq("t2_valid_early", 32'(v0), 32'h0);
            end
            if (n == 7) begin
                check_eq("t2_press_gone", 32'(pp0), 32'h0);
                check_eq("t2_sel", 32'(sel0), 32'h1);
                check_eq("t2_valid", 32'(v0), 32'h1);
            end
        end
        repeat (12) step(1'b0, 4'hF);

        // Bounce on button 2, then held.
        presses = 0;
        for (int c = 0; c < 8; c++) begin
            step(1'b0, (c % 2 == 0) ? 4'hB : 4'hF);
            check_eq("t3_bounce_db", 32'(db0[2]), 32'h1);
            presses += int'(pp0[2]);
        end
        for (int n = 1; n <= 6; n++) begin
            step(1'b0, 4'hB);
            presses += int'(pp0[2]);
            if (n == 5) check_eq("t3_db_early", 32'(db0[2]), 32'h1);
            if (n == 6) check_eq("t3_db", 32'(db0[2]), 32'h0);
        end
        repeat (3) begin
            step(1'b0, 4'hB);
            presses += int'(pp0[2]);
        end
        check_eq("t3_press_count", 32'(presses), 32'h1);
        check_eq("t3_sel", 32'(sel0), 32'h2);
        repeat (12) step(1'b0, 4'hF);

        // Simultaneous press of buttons 0 and 3, then release.
        for (int n = 1; n <= 7; n++) begin
            step(1'b0, 4'h6);
            if (n == 6) check_eq("t4_press", 32'(pp0), 32'h9);
            if (n == 7) check_eq("t4_sel", 32'(sel0), 32'h0);
        end
        for (int n = 1; n <= 7; n++) begin
            step(1'b0, 4'hF);
            if (n == 6) check_eq("t4_release", 32'(rp0), 32'h9);
            if (n == 7) check_eq("t4_sel_hold", 32'(sel0), 32'h0);
        end

        // Reset in the middle of a count on button 3.
        repeat (3) step(1'b0, 4'h7);
        step(1'b1, 4'h7);
        check_eq("t5_db_rst", 32'(db0), 32'hF);
        check_eq("t5_valid_rst", 32'(v0), 32'h0);
        for (int n = 1; n <= 6; n++) begin
            step(1'b0, 4'h7);
            if (n == 5) check_eq("t5_db_early", 32'(db0[3]), 32'h1);
            if (n == 6) check_eq("t5_db", 32'(db0[3]), 32'h0);
        end
        repeat (12) step(1'b0, 4'hF);

        // One-cycle raw pulse on button 0 seen by the DEBOUNCE_CYCLES=1 instance.
        step(1'b0, 4'hE);
        step(1'b0, 4'hF);
        step(1'b0, 4'hF);
        check_eq("t6_db_low", 32'(db1[0]), 32'h0);
        check_eq("t6_press", 32'(pp1), 32'h1);
        step(1'b0, 4'hF);
        check_eq("t6_db_high", 32'(db1[0]), 32'h1);
        check_eq("t6_release", 32'(rp1), 32'h1);
        check_eq("t6_press_gone", 32'(pp1), 32'h0);
        check_eq("t6_db0_ignored", 32'(db0[0]), 32'h1);

        // Random: alternating calm and noisy stretches, occasional reset.
        r = 4'hF;
        noisy = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) noisy = int'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                if (noisy != 0) begin
                    if ($urandom_range(0, 2) == 0) r[i] = ~r[i];
                end else if ($urandom_range(0, 49) == 0) begin
                    r[i] = ~r[i];
                end
            end
            step(($urandom_range(0, 499) == 0), r);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_debounce_sel.md
Name: btn_debounce_sel

Overview:
Front-end conditioning stage for the four active-low board push-buttons before they reach the CPU register monitor's btn_n input.
- Synchronises each raw pin into clk with a two-flop chain.
- Debounces each button independently with a saturating stability counter.
- Emits clean active-low levels plus single-cycle press and release strobes.
- Keeps a latched "last pressed button" selector, so the monitor can hold a register view after the button is released.

Parameters:
N_BTN, 4, number of buttons handled; all per-button logic is replicated N_BTN times.
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a level change is accepted; legal range 1..2^CNT_W-1.
CNT_W, 16, width of each per-button stability counter.

Ports:
clk  input  1  system clock; single clock domain.
reset  input  1  synchronous, active-high reset.
btn_raw_n  input  N_BTN  raw asynchronous button pins; 0 = pressed.
btn_db_n  output  N_BTN  debounced levels; 0 = pressed; drives the monitor's btn_n.
press_pulse  output  N_BTN  one-cycle strobe, bit i high when btn_db_n[i] goes 1->0.
release_pulse  output  N_BTN  one-cycle strobe, bit i high when btn_db_n[i] goes 0->1.
sel_idx  output  2  index of the most recently pressed button.
sel_valid  output  1  high once any press has been accepted since reset.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high. All state updates only on the rising edge of clk; reset is sampled on that edge.
- Reset values:
  - sync1, sync2 and btn_db_n all = all-ones (all buttons released).
  - Counters = 0.
  - press_pulse = 0, release_pulse = 0.
  - sel_idx = 0, sel_valid = 0.
- Reset mid-debounce: any partially counted change is discarded. Reset has priority over every other update in the same edge.
- Synchroniser: sync1 <= btn_raw_n; sync2 <= sync1. Only sync2 feeds the debounce logic.
- Debounce, per button i, evaluated every edge:
  - If sync2[i] == btn_db_n[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: btn_db_n[i] <= sync2[i], cnt[i] <= 0, and the matching strobe is asserted.
  - Else: cnt[i] <= cnt[i]+1.
- Bounce handling: a single cycle where sync2 matches btn_db_n restarts the count from 0. The counter never wraps.
- Latency: raw change set up before edge E0 → btn_db_n changes on edge E0+DEBOUNCE_CYCLES+1.
  - DEBOUNCE_CYCLES=1: change on edge E0+2.
- Strobes: registered and asserted for exactly the one cycle following the btn_db_n transition edge, i.e. coincident with the new btn_db_n value. press_pulse and release_pulse of the same bit are never high together.
- Selector: on an edge where press_pulse has any bit set, sel_idx <= index of the lowest set bit and sel_valid <= 1.
  - Simultaneous presses: lowest index wins.
  - Releases do not change sel_idx.
  - Value is held until the next press or reset.
  - Selector update is one cycle after the press strobe.
  - N_BTN > 4: sel_idx is extended accordingly (width ceil(log2 N_BTN)).
- Independence: buttons never interact except through the selector priority.

Test Plan:
1. Reset release, DEBOUNCE_CYCLES=4, btn_raw_n=4'hF held → btn_db_n=4'hF, strobes 0, sel_idx=0, sel_valid=0 for 20 cycles.
2. btn_raw_n[1] driven 0 before edge E0 and held → btn_db_n=4'hD after edge E0+5; press_pulse=4'h2 for exactly one cycle; sel_idx=1 and sel_valid=1 one cycle later.
3. Bounce: btn_raw_n[2] toggles 0,1,0,1 each cycle for 8 cycles, then held 0 → no change during bounce; btn_db_n[2]=0 exactly 5 edges after the last 1→0 raw change; single press_pulse.
4. Simultaneous: btn_raw_n goes 4'hF→4'h6 on one edge → press_pulse=4'h9 in one cycle; sel_idx=0. Then release all → release_pulse=4'h9; sel_idx stays 0.
5. Reset mid-count: btn_raw_n[3]=0 for 3 cycles, reset for 1 cycle, btn_raw_n[3] kept 0 → count restarts; btn_db_n[3] falls 6 edges after reset deasserts (2-flop resync + 4).
6. DEBOUNCE_CYCLES=1 build: single-cycle raw pulse on btn_raw_n[0] → btn_db_n[0] low for exactly one cycle, press_pulse then release_pulse on consecutive cycles.
